// File: rtl/spi_master_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_master_pkg : shared FSM state encoding and latched transfer mode bits   |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Width-independent part of the latched configuration; divider, select and
    // length are parameter-sized and are held alongside it in the top level.
    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_cfg_t;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_clk_gen : SCLK half-period divider with leading/trailing edge strobes   |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             toggle_en,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             lead,
    output logic             trail
);

    logic [DIV_W-1:0] cnt;
    logic             phase;

    assign tick  = en && (cnt == div);
    assign lead  = tick && toggle_en && !phase;
    assign trail = tick && toggle_en && phase;

    // Counter restarts whenever the FSM parks (IDLE/LOAD) so each word starts
    // with a full half-period before its first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            if (!en || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (!toggle_en) begin
                phase <= 1'b0;
            end else if (tick) begin
                phase <= ~phase;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_master_mc : multi-slave SPI master, CPOL/CPHA, multi-word transactions  |
// | Option macro  : SPI_MASTER_LSB_FIRST_EN adds lsb_first_i (LSB-first order)  |
// | Revision      : 1.0                                                         |
// +-----------------------------------------------------------------------------+
module spi_master_mc
    import spi_master_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 3,
    parameter int DIV_W  = 8,
    parameter int LEN_W  = 13,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CS_W-1:0]   cs_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic [LEN_W-1:0]  xfer_len_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first_i,
`endif
    output logic [NUM_CS-1:0] cs_no
);

    localparam int             EC_W        = $clog2(2 * DATA_W);
    localparam logic [EC_W-1:0] LAST_EDGE  = EC_W'(2 * DATA_W - 1);
    localparam logic [EC_W-1:0] LAST_SMP0  = EC_W'(2 * DATA_W - 2);

    state_t              state, state_next;
    spi_cfg_t            cfg;
    logic [DIV_W-1:0]    div_q;
    logic [LEN_W-1:0]    word_cnt;
    logic [EC_W-1:0]     edge_cnt;
    logic [DATA_W-1:0]   tx_sr, rx_sr;
    logic [DATA_W-1:0]   load_shifted, sr_shifted, rx_next;
    logic                load_bit, sr_bit;
    logic [NUM_CS-1:0]   cs_dec;
    logic                lsb_in, start_ok, tick, lead, trail;
    logic                last_edge, last_sample, sample_stb, shift_stb;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first_i;
`else
    assign lsb_in = 1'b0;
`endif

    assign start_ok    = start_i && (int'(cs_sel_i) < NUM_CS) && (xfer_len_i != '0);
    assign busy_o      = (state != IDLE);
    assign tx_ready_o  = (state == LOAD);
    assign last_edge   = (edge_cnt == LAST_EDGE);
    assign last_sample = (edge_cnt == (cfg.cpha ? LAST_EDGE : LAST_SMP0));
    assign sample_stb  = cfg.cpha ? trail : lead;
    assign shift_stb   = cfg.cpha ? lead : (trail && !last_edge);

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .en        ((state == SETUP) || (state == SHIFT) || (state == HOLD)),
        .toggle_en (state == SHIFT),
        .div       (div_q),
        .tick      (tick),
        .lead      (lead),
        .trail     (trail)
    );

    always_comb begin
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (cs_sel_i != CS_W'(i));
        end
    end

    always_comb begin
        if (cfg.lsb_first) begin
            load_bit     = tx_data_i[0];
            load_shifted = tx_data_i >> 1;
            sr_bit       = tx_sr[0];
            sr_shifted   = tx_sr >> 1;
            rx_next      = {miso_i, rx_sr[DATA_W-1:1]};
        end else begin
            load_bit     = tx_data_i[DATA_W-1];
            load_shifted = tx_data_i << 1;
            sr_bit       = tx_sr[DATA_W-1];
            sr_shifted   = tx_sr << 1;
            rx_next      = {rx_sr[DATA_W-2:0], miso_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok)   state_next = SETUP;
            SETUP:   if (tick)       state_next = LOAD;
            LOAD:    if (tx_valid_i) state_next = SHIFT;
            SHIFT:   if (tick && last_edge)
                         state_next = (word_cnt == LEN_W'(1)) ? HOLD : LOAD;
            HOLD:    if (tick)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg        <= '0;
            div_q      <= '0;
            word_cnt   <= '0;
            edge_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            sclk_o     <= 1'b0;
            mosi_o     <= 1'b0;
            cs_no      <= '1;
        end else begin
            rx_valid_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cfg      <= '{cpol: cpol_i, cpha: cpha_i, lsb_first: lsb_in};
                        div_q    <= clk_div_i;
                        word_cnt <= xfer_len_i;
                        edge_cnt <= '0;
                        sclk_o   <= cpol_i;
                        cs_no    <= cs_dec;
                    end else if (start_i) begin
                        err_o <= 1'b1;
                    end
                end
                LOAD: begin
                    // CPHA=0 must present the first bit before the leading edge.
                    if (tx_valid_i) begin
                        if (!cfg.cpha) begin
                            mosi_o <= load_bit;
                            tx_sr  <= load_shifted;
                        end else begin
                            tx_sr  <= tx_data_i;
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk_o   <= ~sclk_o;
                        edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
                        if (sample_stb) begin
                            rx_sr <= rx_next;
                            if (last_sample) begin
                                rx_data_o  <= rx_next;
                                rx_valid_o <= 1'b1;
                            end
                        end
                        if (shift_stb) begin
                            mosi_o <= sr_bit;
                            tx_sr  <= sr_shifted;
                        end
                        if (last_edge) begin
                            word_cnt <= word_cnt - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_no  <= '1;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_spi_master_mc : scoreboard bench for spi_master_mc (loopback/slave model)|
// | Revision         : 1.0                                                      |
// +-----------------------------------------------------------------------------+
module tb_spi_master_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, cpol = 1'b0, cpha = 1'b0, tx_valid = 1'b0;
    logic [1:0]  cs_sel = '0;
    logic [7:0]  clk_div = '0;
    logic [12:0] xfer_len = '0;
    logic [7:0]  tx_data = '0;
    logic        tx_ready, rx_valid, busy, done, err, sclk, mosi, miso;
    logic [7:0]  rx_data;
    logic [2:0]  cs_n;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic        lsb_first = 1'b0;
`endif

    int          checks = 0, errors = 0;
    int          cyc = 0, sclk_edges = 0, rise_gap = 0, last_rise = 0;
    int          done_cnt = 0, err_cnt = 0, rx_cnt = 0, cs_bad = 0;
    bit          busy_seen = 0, cs_track = 0, loopback = 1;
    logic        sclk_prev = 1'b0;
    logic [2:0]  cs_exp = 3'b111;
    logic [7:0]  exp_q[$];

    logic        slv_bit = 1'b0, slv_cpol = 1'b0;
    int          slv_idx = 0;
    logic [7:0]  slv_pat = 8'h3C;

    always #5 clk = ~clk;

    spi_master_mc dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .cs_sel_i   (cs_sel),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .clk_div_i  (clk_div),
        .xfer_len_i (xfer_len),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .sclk_o     (sclk),
        .mosi_o     (mosi),
        .miso_i     (miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first_i(lsb_first),
`endif
        .cs_no      (cs_n)
    );

    assign miso = loopback ? mosi : slv_bit;

    // CPHA=1 slave: drives its next bit on every leading edge.
    always @(sclk) begin
        if (!loopback && sclk != slv_cpol) begin
            slv_bit = slv_pat[7 - slv_idx];
            slv_idx = (slv_idx + 1) % 8;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sclk !== sclk_prev) begin
            sclk_edges++;
            if (sclk === 1'b1) begin
                if (last_rise != 0) rise_gap = cyc - last_rise;
                last_rise = cyc;
            end
        end
        sclk_prev = sclk;
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (busy) busy_seen = 1;
        if (cs_track && busy && cs_n !== cs_exp) cs_bad++;
        if (rx_valid) begin
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected got=%h required=none", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data got=%h required=%h", rx_data, e);
                end
            end
        end
    end

    task automatic do_start(input logic p, input logic h, input logic [7:0] d,
                            input logic [1:0] s, input logic [12:0] n);
        done_cnt = 0; err_cnt = 0; rx_cnt = 0; last_rise = 0;
        @(negedge clk);
        cpol = p; cpha = h; clk_div = d; cs_sel = s; xfer_len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 sclk_edges = 0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic [7:0] e, input bit push);
        int t;
        t = 0;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        tx_data = w; tx_valid = 1'b1;
        while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_handshake ready=%b required=1", tx_ready);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done_cnt == 0 && t < budget) begin @(negedge clk); t++; end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout pulses=%0d required=1", done_cnt);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cs_n !== 3'b111) begin errors++; $display("FAIL reset_cs got=%b required=111", cs_n); end
        checks++; if (sclk !== 1'b0)   begin errors++; $display("FAIL reset_sclk got=%b required=0", sclk); end
        checks++; if (mosi !== 1'b0)   begin errors++; $display("FAIL reset_mosi got=%b required=0", mosi); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h required=00", rx_data); end
        checks++; if ({rx_valid, done, err, busy, tx_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b required=00000", {rx_valid, done, err, busy, tx_ready});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_loopback();
        loopback = 1;
        do_start(1'b0, 1'b0, 8'd1, 2'd0, 13'd1);
        checks++; if (cs_n !== 3'b110 || busy !== 1'b1) begin
            errors++; $display("FAIL m0_setup cs=%b busy=%b required cs=110 busy=1", cs_n, busy);
        end
        send_word(8'hA5, 8'hA5, 1);
        wait_done(2000);
        checks++; if (sclk_edges != 16) begin errors++; $display("FAIL m0_edges got=%0d required=16", sclk_edges); end
        checks++; if (rise_gap != 4)    begin errors++; $display("FAIL m0_period got=%0d required=4", rise_gap); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL m0_done got=%0d required=1", done_cnt); end
        checks++; if (rx_cnt != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL m0_rx_count got=%0d pending=%0d required=1/0", rx_cnt, exp_q.size());
        end
        checks++; if (cs_n !== 3'b111 || busy !== 1'b0 || sclk !== 1'b0) begin
            errors++; $display("FAIL m0_idle cs=%b busy=%b sclk=%b required 111/0/0", cs_n, busy, sclk);
        end
    endtask

    task automatic test_mode3_multiword();
        loopback = 0; slv_cpol = 1'b1; slv_idx = 0; slv_pat = 8'h3C;
        cs_exp = 3'b011; cs_bad = 0; cs_track = 1;
        do_start(1'b1, 1'b1, 8'd2, 2'd2, 13'd3);
        send_word(8'h01, 8'h3C, 1);
        send_word(8'h80, 8'h3C, 1);
        send_word(8'hFF, 8'h3C, 1);
        wait_done(5000);
        cs_track = 0;
        checks++; if (cs_bad != 0)      begin errors++; $display("FAIL m3_cs_held bad_cycles=%0d required=0", cs_bad); end
        checks++; if (rx_cnt != 3)      begin errors++; $display("FAIL m3_rx_count got=%0d required=3", rx_cnt); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL m3_done got=%0d required=1", done_cnt); end
        checks++; if (sclk !== 1'b1)    begin errors++; $display("FAIL m3_sclk_idle got=%b required=1", sclk); end
        checks++; if (sclk_edges != 48) begin errors++; $display("FAIL m3_edges got=%0d required=48", sclk_edges); end
        loopback = 1;
    endtask

    task automatic test_underflow_mode1();
        int t, stall_bad;
        t = 0; stall_bad = 0;
        loopback = 1;
        do_start(1'b0, 1'b1, 8'd1, 2'd0, 13'd2);
        send_word(8'hA1, 8'hA1, 1);
        while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
        repeat (10) begin
            @(negedge clk);
            if (sclk !== 1'b0 || cs_n !== 3'b110 || tx_ready !== 1'b1) stall_bad++;
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL m1_stall bad_cycles=%0d required=0", stall_bad); end
        send_word(8'h5E, 8'h5E, 1);
        wait_done(3000);
        checks++; if (rx_cnt != 2)      begin errors++; $display("FAIL m1_rx_count got=%0d required=2", rx_cnt); end
        checks++; if (sclk_edges != 32) begin errors++; $display("FAIL m1_edges got=%0d required=32", sclk_edges); end
    endtask

    task automatic test_start_errors();
        busy_seen = 0;
        do_start(1'b0, 1'b0, 8'd1, 2'd3, 13'd1);
        repeat (3) @(negedge clk);
        checks++; if (err_cnt != 1 || cs_n !== 3'b111) begin
            errors++; $display("FAIL err_bad_sel pulses=%0d cs=%b required 1/111", err_cnt, cs_n);
        end
        do_start(1'b0, 1'b0, 8'd1, 2'd0, 13'd0);
        repeat (3) @(negedge clk);
        checks++; if (err_cnt != 1 || cs_n !== 3'b111) begin
            errors++; $display("FAIL err_zero_len pulses=%0d cs=%b required 1/111", err_cnt, cs_n);
        end
        checks++; if (busy_seen != 0 || done_cnt != 0) begin
            errors++; $display("FAIL err_busy busy_seen=%0d done=%0d required 0/0", busy_seen, done_cnt);
        end
    endtask

    task automatic test_abort_mode2();
        int t;
        t = 0;
        loopback = 1;
        do_start(1'b1, 1'b0, 8'd3, 2'd1, 13'd2);
        send_word(8'hC3, 8'h00, 0);
        while (sclk_edges < 5 && t < 2000) begin @(negedge clk); t++; end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cs_n !== 3'b111 || sclk !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_outputs cs=%b sclk=%b busy=%b required 111/0/0", cs_n, sclk, busy);
        end
        done_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != 0 || rx_cnt != 0) begin
            errors++; $display("FAIL abort_no_done done=%0d rx=%0d required 0/0", done_cnt, rx_cnt);
        end
        do_start(1'b0, 1'b0, 8'd0, 2'd1, 13'd1);
        send_word(8'h5A, 8'h5A, 1);
        wait_done(2000);
        checks++; if (done_cnt != 1 || rx_cnt != 1 || sclk_edges != 16) begin
            errors++; $display("FAIL abort_restart done=%0d rx=%0d edges=%0d required 1/1/16", done_cnt, rx_cnt, sclk_edges);
        end
        checks++; if (rise_gap != 2) begin errors++; $display("FAIL div0_period got=%0d required=2", rise_gap); end
    endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
    task automatic test_lsb_first();
        int t;
        t = 0;
        loopback = 1; lsb_first = 1'b1;
        do_start(1'b0, 1'b0, 8'd1, 2'd0, 13'd1);
        send_word(8'h01, 8'h01, 1);
        while (sclk_edges < 1 && t < 2000) begin @(negedge clk); t++; end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got=%b required=1", mosi); end
        wait_done(2000);
        lsb_first = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_multiword();
        test_underflow_mode1();
        test_start_errors();
        test_abort_mode2();
`ifdef SPI_MASTER_LSB_FIRST_EN
        test_lsb_first();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
